series_datapath: RTL

- Datapath responder for the iterative alternating-series evaluator (cos(x) Taylor expansion).
- Executes register-transfer strobes issued cycle by cycle by the series controller: init, load, four multiply steps, compare, sub/add.
- Returns the continue flag `en` and the fixed-point result.
- Contains no internal sequencing; every register update is caused by a strobe in that cycle.

---
 rtl/series_pkg.sv | 16 +
 rtl/series_datapath_if.sv | 30 +++
 rtl/series_coef_rom.sv | 28 ++
 rtl/series_datapath.sv | 118 +++++++++++
 4 files changed

// File: rtl/series_pkg.sv
// Shared constants and the coefficient helper for the cos(x) series datapath.
package series_pkg;

    localparam int WIDTH_DEF   = 16;
    localparam int FRAC_DEF    = 14;
    localparam int N_TERMS_DEF = 4;
    localparam int ONE         = 1 << FRAC_DEF;

    // round(2^frac/(k+1)): divide at double scale, add one half-LSB, halve.
    function automatic int coef_of(input int k, input int frac);
        int scaled;
        scaled = (32'sd1 << (frac + 1)) / (k + 1);
        return (scaled + 32'sd1) >>> 1;
    endfunction

endpackage

// File: rtl/series_datapath_if.sv
// Strobe bus between the series controller (master) and the datapath (slave).
interface series_datapath_if #(
    parameter int WIDTH = 16
) ();
    logic [WIDTH-1:0] x_in;
    logic             loadx;
    logic             t_init;
    logic             loadt;
    logic             select;
    logic             counter_init;
    logic             enc;
    logic             r_init;
    logic             loadr;
    logic             ci_adder;
    logic             en;
    logic [WIDTH+1:0] result;
    logic             ovf;

    modport master (
        output x_in, loadx, t_init, loadt, select, counter_init, enc,
               r_init, loadr, ci_adder,
        input  en, result, ovf
    );

    modport slave (
        input  x_in, loadx, t_init, loadt, select, counter_init, enc,
               r_init, loadr, ci_adder,
        output en, result, ovf
    );
endinterface

// File: rtl/series_coef_rom.sv
// Combinational lookup of the 1/(k+1) series coefficients; indices past the
// last term read as zero.
module series_coef_rom
    import series_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int FRAC    = FRAC_DEF,
    parameter int N_TERMS = N_TERMS_DEF,
    parameter int CW      = $clog2(2 * N_TERMS + 1)
) (
    input  logic [CW-1:0]    count,
    output logic [WIDTH-1:0] coef
);
    localparam int DEPTH = 1 << CW;

    logic [WIDTH-1:0] rom_s [0:DEPTH-1];

    for (genvar k = 0; k < DEPTH; k++) begin : g_coef
        if (k < 2 * N_TERMS) begin : g_used
            localparam logic [31:0] FULL = 32'(coef_of(k, FRAC));
            assign rom_s[k] = FULL[WIDTH-1:0];
        end else begin : g_zero
            assign rom_s[k] = '0;
        end
    end

    assign coef = rom_s[count];
endmodule

// File: rtl/series_datapath.sv
// Register-transfer datapath for the alternating cos(x) series: x, term t,
// running sum r and term counter, each updated only by controller strobes.
module series_datapath
    import series_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int FRAC    = FRAC_DEF,
    parameter int N_TERMS = N_TERMS_DEF
) (
    input  logic            clk,
    input  logic            rst,
    series_datapath_if.slave bus
);
    localparam int CW = $clog2(2 * N_TERMS + 1);
    localparam logic [CW-1:0]    LAST    = CW'(2 * N_TERMS);
    localparam logic [WIDTH-1:0] ONE_T   = WIDTH'(1) << FRAC;
    localparam logic [WIDTH+1:0] ONE_R   = (WIDTH + 2)'(1) << FRAC;
    localparam logic [WIDTH+1:0] R_MAX   = {1'b0, {(WIDTH + 1){1'b1}}};
    localparam logic [WIDTH+1:0] R_MIN   = {1'b1, {(WIDTH + 1){1'b0}}};

    logic [WIDTH-1:0]   x_r;
    logic [WIDTH-1:0]   t_r;
    logic [WIDTH+1:0]   r_r;
    logic [CW-1:0]      count_r;
    logic               ovf_r;

    logic [WIDTH-1:0]   coef_s;
    logic [WIDTH-1:0]   operand_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] quot_s;
    logic [WIDTH-1:0]   t_mul_s;
    logic [WIDTH+2:0]   sum_s;
    logic [WIDTH+1:0]   r_add_s;
    logic               sat_s;

    series_coef_rom #(
        .WIDTH   (WIDTH),
        .FRAC    (FRAC),
        .N_TERMS (N_TERMS),
        .CW      (CW)
    ) u_rom (
        .count (count_r),
        .coef  (coef_s)
    );

    // Saturating fixed-point multiply of t by x or the current coefficient.
    always_comb begin
        operand_s = x_r;
        if (bus.select) begin
            operand_s = coef_s;
        end else begin
            operand_s = x_r;
        end
        prod_s = {{WIDTH{1'b0}}, t_r} * {{WIDTH{1'b0}}, operand_s};
        quot_s = prod_s >> FRAC;
        if (|quot_s[2*WIDTH-1:WIDTH]) begin
            t_mul_s = '1;
        end else begin
            t_mul_s = quot_s[WIDTH-1:0];
        end
    end

    // Saturating add/subtract of the zero-extended term into the signed sum;
    // one guard bit catches leaving the signed WIDTH+2 range.
    always_comb begin
        if (bus.ci_adder) begin
            sum_s = {r_r[WIDTH+1], r_r} - {3'b000, t_r};
        end else begin
            sum_s = {r_r[WIDTH+1], r_r} + {3'b000, t_r};
        end
        sat_s = (sum_s[WIDTH+2] != sum_s[WIDTH+1]);
        if (!sat_s) begin
            r_add_s = sum_s[WIDTH+1:0];
        end else if (sum_s[WIDTH+2]) begin
            r_add_s = R_MIN;
        end else begin
            r_add_s = R_MAX;
        end
    end

    // Strobe-driven register updates; init strobes win over their load strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r     <= '0;
            t_r     <= '0;
            r_r     <= '0;
            count_r <= '0;
            ovf_r   <= 1'b0;
        end else begin
            if (bus.loadx) begin
                x_r <= bus.x_in;
            end
            if (bus.t_init) begin
                t_r <= ONE_T;
            end else if (bus.loadt) begin
                t_r <= t_mul_s;
            end
            if (bus.r_init) begin
                r_r   <= ONE_R;
                ovf_r <= 1'b0;
            end else if (bus.loadr) begin
                r_r <= r_add_s;
                if (sat_s) begin
                    ovf_r <= 1'b1;
                end
            end
            if (bus.counter_init) begin
                count_r <= '0;
            end else if (bus.enc && (count_r != LAST)) begin
                count_r <= count_r + CW'(1);
            end
        end
    end

    assign bus.en     = (count_r < LAST);
    assign bus.result = r_r;
    assign bus.ovf    = ovf_r;
endmodule
